// File: rtl/comms_engine_pkg.sv
// Shared types and packet field offsets for the parametrised ring
// communication engine (control ring REQ/ACK/NACK + data plane bursts).
package comms_engine_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_REQ  = 2'b01,
    OP_ACK  = 2'b10,
    OP_NACK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b00,
    TX_REQ  = 2'b01,
    TX_WAIT = 2'b10,
    TX_SEND = 2'b11
  } tx_state_e;

  // Control packet layout, MSB to LSB: {op[1:0], src, dst, len}
  function automatic int cpkt_dst_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int cpkt_src_lsb(input int node_w, input int len_w);
    return len_w + node_w;
  endfunction

  function automatic int cpkt_op_lsb(input int node_w, input int len_w);
    return len_w + 2 * node_w;
  endfunction

  // Data packet layout, MSB to LSB: {valid, last, src, payload}
  function automatic int dpkt_src_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int dpkt_last_bit(input int node_w, input int data_w);
    return data_w + node_w;
  endfunction

  function automatic int dpkt_valid_bit(input int node_w, input int data_w);
    return data_w + node_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; a pop from
// an empty FIFO is ignored. The head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/comms_engine_param.sv
// Per-node ring communication engine: forwards/answers control-ring
// reservations, injects its own REQ into idle slots, bursts the TX FIFO
// on the data plane once ACKed, and collects reserved data into the RX FIFO.
// Optional macro RETRY_EN: NACK/timeout re-requests up to MAX_RETRY times
// before reporting tx_error.
module comms_engine_param
  import comms_engine_pkg::*;
#(
  parameter int NODE_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3,
  localparam int LEN_W  = $clog2(DEPTH + 1),
  localparam int CPKT_W = 2 + 2 * NODE_W + LEN_W,
  localparam int DPKT_W = 2 + NODE_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] node_id,
  input  logic [NODE_W-1:0] max_node,
  input  logic [CPKT_W-1:0] control_rx_packet,
  output logic [CPKT_W-1:0] control_tx_packet,
  input  logic [DPKT_W-1:0] data_rx_packet,
  output logic [DPKT_W-1:0] data_tx_packet,
  output logic [NODE_W-1:0] data_rx_node_id,
  input  logic              gpp_tx_wr,
  input  logic [DATA_W-1:0] gpp_tx_data,
  output logic              tx_full,
  input  logic              tx_start,
  input  logic [NODE_W-1:0] tx_dst,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error,
  output logic              data_rx_flag,
  output logic              rx_avail,
  input  logic              gpp_rx_rd,
  output logic [DATA_W-1:0] RAM_rx_data_out,
  output logic [LEN_W-1:0]  rx_count
);

  localparam int C_DST = cpkt_dst_lsb(LEN_W);
  localparam int C_SRC = cpkt_src_lsb(NODE_W, LEN_W);
  localparam int C_OP  = cpkt_op_lsb(NODE_W, LEN_W);
  localparam int D_SRC = dpkt_src_lsb(DATA_W);
  localparam int D_LST = dpkt_last_bit(NODE_W, DATA_W);
  localparam int D_VLD = dpkt_valid_bit(NODE_W, DATA_W);
  localparam int TW    = $clog2(TIMEOUT + 1);

  op_e               crx_op;
  logic [NODE_W-1:0] crx_src, crx_dst;
  logic [LEN_W-1:0]  crx_len;
  logic              drx_valid, drx_last;
  logic [NODE_W-1:0] drx_src;
  logic [DATA_W-1:0] drx_data;

  tx_state_e         state, state_nx;
  logic [NODE_W-1:0] dst_l;
  logic [LEN_W-1:0]  len_l, left;
  logic [TW-1:0]     timer;
  logic [LEN_W-1:0]  tx_count;
  logic [DATA_W-1:0] tx_head;
  logic              tx_empty, rx_empty, tx_push, rx_accept;
  logic              slot_free, to_me, req_in, grant, ack_in, nack_in;
  logic              start_ok, wait_fail, retry_left;
  logic              inject, tx_pop, done_set, err_set;

  assign crx_op    = op_e'(control_rx_packet[C_OP +: 2]);
  assign crx_src   = control_rx_packet[C_SRC +: NODE_W];
  assign crx_dst   = control_rx_packet[C_DST +: NODE_W];
  assign crx_len   = control_rx_packet[LEN_W-1:0];
  assign drx_valid = data_rx_packet[D_VLD];
  assign drx_last  = data_rx_packet[D_LST];
  assign drx_src   = data_rx_packet[D_SRC +: NODE_W];
  assign drx_data  = data_rx_packet[DATA_W-1:0];

  assign slot_free = (crx_op == OP_IDLE);
  assign to_me     = !slot_free && (crx_dst == node_id);
  assign req_in    = to_me && (crx_op == OP_REQ);
  assign grant     = req_in && !data_rx_flag && (crx_len <= (LEN_W'(DEPTH) - rx_count));
  assign ack_in    = to_me && (crx_op == OP_ACK) && (crx_src == dst_l);
  assign nack_in   = to_me && (crx_op == OP_NACK) && (crx_src == dst_l);
  assign start_ok  = tx_start && !tx_empty && (tx_dst < max_node) && (tx_dst != node_id);
  assign wait_fail = (state == TX_WAIT) && !ack_in && (nack_in || (timer == TW'(TIMEOUT - 1)));
  assign rx_accept = data_rx_flag && drx_valid && (drx_src == data_rx_node_id);
  assign tx_push   = gpp_tx_wr && (state == TX_IDLE) && !tx_full;

  assign tx_busy  = (state != TX_IDLE);
  assign tx_full  = (tx_count == LEN_W'(DEPTH));
  assign rx_avail = !rx_empty;

`ifdef RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry;

  assign retry_left = (retry < RW'(MAX_RETRY));

  // Retry counter: counts failed attempts, cleared whenever the FSM idles
  always_ff @(posedge clk) begin
    if (rst || state == TX_IDLE) retry <= '0;
    else if (wait_fail && retry_left) retry <= retry + RW'(1);
  end
`else
  assign retry_left = 1'b0;
`endif

  // TX FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nx;
  end

  // TX FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      TX_IDLE: if (start_ok) state_nx = TX_REQ;
      TX_REQ:  if (slot_free) state_nx = TX_WAIT;
      TX_WAIT: begin
        if (ack_in)         state_nx = TX_SEND;
        else if (wait_fail) state_nx = retry_left ? TX_REQ : TX_IDLE;
      end
      TX_SEND: if (left == LEN_W'(1)) state_nx = TX_IDLE;
      default: state_nx = TX_IDLE;
    endcase
  end

  // TX FSM outputs; a REQ only goes out in an idle slot so traffic keeps priority
  always_comb begin
    inject   = (state == TX_REQ) && slot_free;
    tx_pop   = (state == TX_SEND);
    done_set = (state == TX_SEND) && (left == LEN_W'(1));
    err_set  = ((state == TX_IDLE) && tx_start && !start_ok) || (wait_fail && !retry_left);
  end

  // Transfer bookkeeping: latched destination/length, words left, WAIT timer
  always_ff @(posedge clk) begin
    if (state == TX_IDLE && start_ok) begin
      dst_l <= tx_dst;
      len_l <= tx_count;
    end
    if (rst) begin
      left  <= '0;
      timer <= '0;
    end else begin
      if (state == TX_IDLE && start_ok) left <= tx_count;
      else if (tx_pop)                  left <= left - LEN_W'(1);
      if (inject)                 timer <= '0;
      else if (state == TX_WAIT)  timer <= timer + TW'(1);
    end
  end

  // Control ring slot: forward foreign traffic, answer our REQs, else inject or idle
  always_ff @(posedge clk) begin
    if (rst)                 control_tx_packet <= '0;
    else if (!slot_free && !to_me)
                             control_tx_packet <= control_rx_packet;
    else if (req_in)         control_tx_packet <= {(grant ? OP_ACK : OP_NACK), node_id, crx_src, crx_len};
    else if (inject)         control_tx_packet <= {OP_REQ, node_id, dst_l, len_l};
    else                     control_tx_packet <= '0;
  end

  // Receive reservation: taken on grant, released by the last accepted word
  always_ff @(posedge clk) begin
    if (rst || (rx_accept && drx_last)) begin
      data_rx_flag    <= 1'b0;
      data_rx_node_id <= node_id;
    end else if (grant) begin
      data_rx_flag    <= 1'b1;
      data_rx_node_id <= crx_src;
    end
  end

  // Data plane output word and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      data_tx_packet <= '0;
      tx_done        <= 1'b0;
      tx_error       <= 1'b0;
    end else begin
      data_tx_packet <= tx_pop ? {1'b1, (left == LEN_W'(1)), node_id, tx_head} : '0;
      tx_done        <= done_set;
      tx_error       <= err_set;
    end
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_push),
    .wdata (gpp_tx_data),
    .rd    (tx_pop),
    .rdata (tx_head),
    .count (tx_count),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (rx_accept),
    .wdata (drx_data),
    .rd    (gpp_rx_rd),
    .rdata (RAM_rx_data_out),
    .count (rx_count),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_comms_engine_param.sv
// Bench for comms_engine_param: directed ring/data-plane scenarios with
// literal expectations, plus a queue-based model of the receive side and
// control-ring replies checked on every cycle.
module tb_comms_engine_param;

  localparam int NW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int LW  = 5;
  localparam int CW  = 2 + 2 * NW + LW;
  localparam int PW  = 2 + NW + DW;
`ifdef RETRY_EN
  localparam int EXP_INJ = 4;
`else
  localparam int EXP_INJ = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] node_id, max_node, tx_dst, data_rx_node_id;
  logic [CW-1:0] control_rx_packet, control_tx_packet;
  logic [PW-1:0] data_rx_packet, data_tx_packet;
  logic          gpp_tx_wr, tx_full, tx_start, tx_busy, tx_done, tx_error;
  logic          data_rx_flag, rx_avail, gpp_rx_rd;
  logic [DW-1:0] gpp_tx_data, RAM_rx_data_out;
  logic [LW-1:0] rx_count;

  always #5 clk = ~clk;

  comms_engine_param dut (
    .clk               (clk),
    .rst               (rst),
    .node_id           (node_id),
    .max_node          (max_node),
    .control_rx_packet (control_rx_packet),
    .control_tx_packet (control_tx_packet),
    .data_rx_packet    (data_rx_packet),
    .data_tx_packet    (data_tx_packet),
    .data_rx_node_id   (data_rx_node_id),
    .gpp_tx_wr         (gpp_tx_wr),
    .gpp_tx_data       (gpp_tx_data),
    .tx_full           (tx_full),
    .tx_start          (tx_start),
    .tx_dst            (tx_dst),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_error          (tx_error),
    .data_rx_flag      (data_rx_flag),
    .rx_avail          (rx_avail),
    .gpp_rx_rd         (gpp_rx_rd),
    .RAM_rx_data_out   (RAM_rx_data_out),
    .rx_count          (rx_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [CW-1:0] cpkt(input logic [1:0] op, input logic [NW-1:0] s,
                                         input logic [NW-1:0] d, input logic [LW-1:0] l);
    return {op, s, d, l};
  endfunction

  function automatic logic [PW-1:0] dpkt(input logic v, input logic l,
                                         input logic [NW-1:0] s, input logic [DW-1:0] w);
    return {v, l, s, w};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: RX reservation, RX FIFO, ring replies
  logic [DW-1:0] mq[$];
  logic          m_flag;
  logic [NW-1:0] m_node;
  logic          m_known;
  logic [CW-1:0] m_ctl;
  bit            m_on = 1'b0;
  logic [1:0]    mo;
  logic [NW-1:0] ms, md;
  logic [LW-1:0] ml;
  logic          m_acc, m_pop, m_gr;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_flag  = 1'b0;
      m_node  = node_id;
      m_known = 1'b1;
      m_ctl   = '0;
    end else begin
      {mo, ms, md, ml} = control_rx_packet;
      m_acc = m_flag && data_rx_packet[PW-1] && (data_rx_packet[DW +: NW] == m_node);
      m_pop = gpp_rx_rd && (mq.size() > 0);
      m_known = 1'b1;
      m_ctl   = '0;
      if (mo != 2'b00 && md != node_id) begin
        m_ctl = control_rx_packet;
      end else if (mo == 2'b01) begin
        m_gr  = !m_flag && (int'(ml) <= DEP - mq.size());
        m_ctl = cpkt(m_gr ? 2'b10 : 2'b11, node_id, ms, ml);
        if (m_gr) begin
          m_flag = 1'b1;
          m_node = ms;
        end
      end else if (mo == 2'b00) begin
        m_known = 1'b0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_acc && mq.size() < DEP) mq.push_back(data_rx_packet[DW-1:0]);
      if (m_acc && data_rx_packet[PW-2]) begin
        m_flag = 1'b0;
        m_node = node_id;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("rx_count", 64'(rx_count), 64'(mq.size()));
      chk("rx_avail", 64'(rx_avail), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("rx_head", 64'(RAM_rx_data_out), 64'(mq[0]));
      else                chk("rx_head_empty", 64'(RAM_rx_data_out), 64'd0);
      chk("rx_flag", 64'(data_rx_flag), 64'(m_flag));
      chk("rx_node", 64'(data_rx_node_id), 64'(m_node));
      if (m_known) chk("ctl_tx", 64'(control_tx_packet), 64'(m_ctl));
    end
  end

  // ---------------- directed stimulus helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset(input logic [NW-1:0] nid);
    rst = 1'b1; node_id = nid; control_rx_packet = '0; data_rx_packet = '0;
    gpp_tx_wr = 1'b0; tx_start = 1'b0; gpp_rx_rd = 1'b0;
    cyc(); cyc();
  endtask

  task automatic push_tx(input logic [DW-1:0] w);
    gpp_tx_wr = 1'b1; gpp_tx_data = w; cyc(); gpp_tx_wr = 1'b0;
  endtask

  task automatic ctl(input logic [CW-1:0] p);
    control_rx_packet = p; cyc(); control_rx_packet = '0;
  endtask

  task automatic drx(input logic [PW-1:0] p, input logic rd);
    data_rx_packet = p; gpp_rx_rd = rd; cyc(); data_rx_packet = '0; gpp_rx_rd = 1'b0;
  endtask

  task automatic start(input logic [NW-1:0] d);
    tx_dst = d; tx_start = 1'b1; cyc(); tx_start = 1'b0;
  endtask

  // Start a 1-word transfer to node 5 that never gets ACKed
  task automatic run_fail(input bit nack, output int inj, output int errs, output int gap);
    int g;
    inj = 0; errs = 0; g = 0; gap = -1;
    start(16'd5);
    for (int i = 0; i < 400 && errs == 0; i++) begin
      cyc();
      control_rx_packet = '0;
      if (control_tx_packet == cpkt(2'b01, 16'd2, 16'd5, 5'd1)) begin
        inj++; g = 0;
        if (nack) control_rx_packet = cpkt(2'b11, 16'd5, 16'd2, 5'd1);
      end else g++;
      if (tx_error) begin errs++; gap = g; end
    end
    control_rx_packet = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (tx_error) errs++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  logic [PW-1:0] bexp [3];
  int k, dones, inj, errs, gap;

  initial begin
    max_node = 16'd8; tx_dst = '0; gpp_tx_data = '0;
    // ---------------- reset state at node 2
    start_reset(16'd2);
    m_on = 1'b1;
    chk("rst_ctl_tx", 64'(control_tx_packet), 64'd0);
    chk("rst_data_tx", 64'(data_tx_packet), 64'd0);
    chk("rst_busy", 64'(tx_busy), 64'd0);
    chk("rst_done", 64'(tx_done), 64'd0);
    chk("rst_err", 64'(tx_error), 64'd0);
    chk("rst_full", 64'(tx_full), 64'd0);
    chk("rst_rxnode", 64'(data_rx_node_id), 64'd2);
    rst = 1'b0;

    // ---------------- normal 3-word transfer 2 -> 5, REQ waits behind traffic
    push_tx(16'h00A1); push_tx(16'h00A2); push_tx(16'h00A3);
    control_rx_packet = cpkt(2'b01, 16'd1, 16'd7, 5'd2);
    start(16'd5);
    chk("busy_after_start", 64'(tx_busy), 64'd1);
    chk("fwd_first", 64'(control_tx_packet), 64'(cpkt(2'b01, 16'd1, 16'd7, 5'd2)));
    cyc();
    chk("fwd_priority", 64'(control_tx_packet), 64'(cpkt(2'b01, 16'd1, 16'd7, 5'd2)));
    control_rx_packet = '0;
    cyc();
    chk("own_req", 64'(control_tx_packet), 64'(cpkt(2'b01, 16'd2, 16'd5, 5'd3)));
    cyc();
    chk("no_reinject", 64'(control_tx_packet), 64'd0);
    ctl(cpkt(2'b10, 16'd5, 16'd2, 5'd3));
    bexp[0] = dpkt(1'b1, 1'b0, 16'd2, 16'h00A1);
    bexp[1] = dpkt(1'b1, 1'b0, 16'd2, 16'h00A2);
    bexp[2] = dpkt(1'b1, 1'b1, 16'd2, 16'h00A3);
    k = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (data_tx_packet[PW-1]) begin
        if (k < 3) chk("burst_word", 64'(data_tx_packet), 64'(bexp[k]));
        k++;
      end
      if (tx_done) dones++;
    end
    chk("burst_len", 64'(k), 64'd3);
    chk("done_pulses", 64'(dones), 64'd1);
    chk("busy_after_done", 64'(tx_busy), 64'd0);
    chk("data_tx_idle", 64'(data_tx_packet), 64'd0);

    // ---------------- rejected starts
    start(16'd5);
    chk("err_empty", 64'(tx_error), 64'd1);
    chk("busy_empty", 64'(tx_busy), 64'd0);
    cyc();
    chk("err_pulse_width", 64'(tx_error), 64'd0);
    push_tx(16'h00B1);
    start(16'd2);
    chk("err_self", 64'(tx_error), 64'd1);
    cyc();
    start(16'd8);
    chk("err_range", 64'(tx_error), 64'd1);
    chk("busy_range", 64'(tx_busy), 64'd0);
    cyc();

    // ---------------- timeout and NACK (re-injection count depends on RETRY_EN)
    run_fail(1'b0, inj, errs, gap);
    chk("timeout_injections", 64'(inj), 64'(EXP_INJ));
    chk("timeout_errors", 64'(errs), 64'd1);
    chk("timeout_cycles", 64'(gap), 64'd64);
    run_fail(1'b1, inj, errs, gap);
    chk("nack_injections", 64'(inj), 64'(EXP_INJ));
    chk("nack_errors", 64'(errs), 64'd1);
    chk("nack_latency", 64'(gap), 64'd1);

    // ---------------- receiver at node 5
    start_reset(16'd5);
    rst = 1'b0;
    chk("rx_node_reset", 64'(data_rx_node_id), 64'd5);
    ctl(cpkt(2'b01, 16'd3, 16'd5, 5'd14));
    chk("ack14", 64'(control_tx_packet), 64'(cpkt(2'b10, 16'd5, 16'd3, 5'd14)));
    for (int i = 0; i < 14; i++) begin
      if (i == 5) drx(dpkt(1'b1, 1'b0, 16'd4, 16'hDEAD), 1'b0);
      drx(dpkt(1'b1, i == 13, 16'd3, 16'(16'h0100 + i)), 1'b0);
    end
    chk("rx14", 64'(rx_count), 64'd14);
    chk("rx14_head", 64'(RAM_rx_data_out), 64'h0100);
    chk("rx14_released", 64'(data_rx_flag), 64'd0);
    ctl(cpkt(2'b01, 16'd2, 16'd5, 5'd4));
    chk("nack_space", 64'(control_tx_packet), 64'(cpkt(2'b11, 16'd5, 16'd2, 5'd4)));
    ctl(cpkt(2'b01, 16'd2, 16'd7, 5'd4));
    chk("fwd_at_5", 64'(control_tx_packet), 64'(cpkt(2'b01, 16'd2, 16'd7, 5'd4)));
    for (int i = 0; i < 4; i++) drx('0, 1'b1);
    chk("rx10", 64'(rx_count), 64'd10);
    chk("rx10_head", 64'(RAM_rx_data_out), 64'h0104);
    ctl(cpkt(2'b01, 16'd2, 16'd5, 5'd4));
    chk("ack_space", 64'(control_tx_packet), 64'(cpkt(2'b10, 16'd5, 16'd2, 5'd4)));
    chk("granted_node", 64'(data_rx_node_id), 64'd2);
    chk("granted_flag", 64'(data_rx_flag), 64'd1);
    ctl(cpkt(2'b01, 16'd6, 16'd5, 5'd1));
    chk("nack_busy", 64'(control_tx_packet), 64'(cpkt(2'b11, 16'd5, 16'd6, 5'd1)));
    for (int i = 0; i < 4; i++) drx(dpkt(1'b1, i == 3, 16'd2, 16'(16'h0200 + i)), 1'b0);
    chk("rx14_again", 64'(rx_count), 64'd14);
    chk("node_restored", 64'(data_rx_node_id), 64'd5);
    for (int i = 0; i < 15; i++) drx('0, 1'b1);
    chk("drained", 64'(rx_count), 64'd0);
    drx(dpkt(1'b1, 1'b1, 16'd5, 16'hBEEF), 1'b0);
    chk("drop_unreserved", 64'(rx_count), 64'd0);

    // ---------------- full RX FIFO, boundary length 16, push+pop at full
    ctl(cpkt(2'b01, 16'd2, 16'd5, 5'd16));
    chk("ack16", 64'(control_tx_packet), 64'(cpkt(2'b10, 16'd5, 16'd2, 5'd16)));
    for (int i = 0; i < 16; i++) drx(dpkt(1'b1, 1'b0, 16'd2, 16'(16'h0300 + i)), 1'b0);
    chk("rx_full", 64'(rx_count), 64'd16);
    drx(dpkt(1'b1, 1'b1, 16'd2, 16'h03FF), 1'b1);
    chk("full_push_pop", 64'(rx_count), 64'd16);
    chk("full_head", 64'(RAM_rx_data_out), 64'h0301);
    ctl(cpkt(2'b01, 16'd2, 16'd5, 5'd1));
    chk("nack_full", 64'(control_tx_packet), 64'(cpkt(2'b11, 16'd5, 16'd2, 5'd1)));

    // ---------------- reset in the middle of SEND at node 2
    start_reset(16'd2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push_tx(16'(16'h0400 + i));
    chk("tx_full", 64'(tx_full), 64'd1);
    start(16'd5);
    cyc();
    chk("own_req16", 64'(control_tx_packet), 64'(cpkt(2'b01, 16'd2, 16'd5, 5'd16)));
    ctl(cpkt(2'b10, 16'd5, 16'd2, 5'd16));
    cyc(); cyc();
    chk("send_word2", 64'(data_tx_packet), 64'(dpkt(1'b1, 1'b0, 16'd2, 16'h0401)));
    rst = 1'b1;
    cyc();
    chk("abort_data_tx", 64'(data_tx_packet), 64'd0);
    chk("abort_busy", 64'(tx_busy), 64'd0);
    chk("abort_full", 64'(tx_full), 64'd0);
    chk("abort_ctl", 64'(control_tx_packet), 64'd0);
    chk("abort_done", 64'(tx_done), 64'd0);
    chk("abort_err", 64'(tx_error), 64'd0);
    rst = 1'b0;
    dones = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (tx_done || tx_error) dones++;
      if (data_tx_packet != '0) k++;
    end
    chk("abort_no_pulse", 64'(dones), 64'd0);
    chk("abort_no_data", 64'(k), 64'd0);
    start(16'd5);
    chk("abort_flushed", 64'(tx_error), 64'd1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comms_engine_param.md
Name: comms_engine_param

Overview:
Parametrised per-node communication engine for the photonic ring. It replaces the fixed 16-bit control/data plane pair with a single block that has configurable node-id width, data width and buffer depth. It implements a REQ/ACK/NACK reservation protocol on the control ring and then a burst transfer on the data plane, with TX and RX FIFOs facing the GPP.

Parameters:
NODE_W, 16, node-id width
DATA_W, 16, payload word width
DEPTH, 16, entries in each of TX FIFO and RX FIFO (power of 2, ≥2)
TIMEOUT, 64, cycles to wait in WAIT for ACK/NACK
MAX_RETRY, 3, retries after NACK/timeout (used only with RETRY_EN)
Derived: LEN_W=$clog2(DEPTH+1); CPKT_W=2+2*NODE_W+LEN_W; DPKT_W=2+NODE_W+DATA_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
node_id  in  NODE_W  this node's id (unique per ring)
max_node  in  NODE_W  number of nodes on ring
control_rx_packet  in  CPKT_W  {op[1:0],src,dst,len}; op 00 IDLE, 01 REQ, 10 ACK, 11 NACK
control_tx_packet  out  CPKT_W  registered control slot to next node
data_rx_packet  in  DPKT_W  {valid,last,src,payload}
data_tx_packet  out  DPKT_W  registered data word out
data_rx_node_id  out  NODE_W  source the receiver is tuned to
gpp_tx_wr  in  1  push gpp_tx_data into TX FIFO
gpp_tx_data  in  DATA_W  TX word
tx_full  out  1  TX FIFO full
tx_start  in  1  begin transfer of all TX FIFO words to tx_dst
tx_dst  in  NODE_W  destination node
tx_busy  out  1  TX FSM not IDLE
tx_done  out  1  1-cycle pulse, transfer finished
tx_error  out  1  1-cycle pulse, transfer abandoned
data_rx_flag  out  1  reservation granted, reception in progress
rx_avail  out  1  RX FIFO non-empty
gpp_rx_rd  in  1  pop RX FIFO
RAM_rx_data_out  out  DATA_W  RX FIFO head (show-ahead)
rx_count  out  LEN_W  RX FIFO occupancy

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM IDLE, control_tx_packet op=IDLE, data_rx_node_id=node_id.
- Control ring, 1-cycle latency. If incoming op≠IDLE and dst≠node_id, forward unchanged. If dst==node_id, consume the packet.
  - REQ is granted with ACK only if data_rx_flag=0 and len ≤ DEPTH−rx_count. On grant: latch src into data_rx_node_id and set data_rx_flag.
  - Otherwise reply NACK.
  - The reply {op,node_id,src,len} occupies the consumed slot.
- Own REQ is injected only into an incoming IDLE slot. Forwarding and replies always take priority.
- TX FSM: IDLE→REQ on tx_start when the TX FIFO is non-empty.
  - Latch dst and len=count. tx_start on an empty FIFO → tx_error, stay IDLE.
  - dst ≥ max_node or dst==node_id → tx_error.
  - REQ→WAIT once injected; the timer starts at 0.
  - WAIT→SEND on ACK with src==latched dst.
  - WAIT→IDLE with tx_error on NACK, or when the timer reaches TIMEOUT.
  - SEND: pop one word per cycle, data_tx_packet={1,last,node_id,word}; last=1 on the final word. Then go to IDLE and pulse tx_done; data_tx_packet returns to 0.
  - tx_start is ignored while tx_busy.
- gpp_tx_wr is ignored while tx_busy or when full.
- Receive: accept data_rx_packet when valid and src==data_rx_node_id, and write it to the RX FIFO. On last, clear data_rx_flag and restore data_rx_node_id=node_id.
  - Packets arriving while data_rx_flag=0 are dropped.
- RX FIFO: simultaneous push and pop in the same cycle keeps the count unchanged. Pop when empty is ignored. Push when full is dropped; this cannot occur under a granted reservation.
- Pointers wrap modulo DEPTH. rx_count saturates at DEPTH.
- Reset mid-operation aborts the transfer, flushes both FIFOs and releases the reservation. No tx_done or tx_error pulse is generated.

Optional Feature:
RETRY_EN.
- With it: NACK or timeout returns the FSM to REQ and increments the retry counter. tx_error fires only after MAX_RETRY retries have failed. The retry counter clears on IDLE.
- Without it: the first NACK or timeout gives tx_error. The retry logic is absent.

Decomposition:
- Package comms_engine_pkg holds:
  - op_e enum (IDLE, REQ, ACK, NACK)
  - tx_state_e (IDLE, REQ, WAIT, SEND)
  - parametrised packet field offset functions
- One sub-module, sync_fifo (params WIDTH, DEPTH; show-ahead, count output), instantiated for TX and RX.

Test Plan:
- NODE_W=16, DATA_W=16, DEPTH=16. Node 2 pushes 3 words 0xA1,0xA2,0xA3, tx_start dst=5. Expect REQ {01,2,5,3} in the next IDLE slot. Drive ACK {10,5,2,3} → 3 data packets, last on 0xA3, then a tx_done pulse.
- Receiver node 5 gets REQ src=2 len=4 with rx_count=14 → NACK {11,5,2,4}. With rx_count=10 → ACK, data_rx_node_id=2, data_rx_flag=1.
- Incoming REQ dst=7 at node 2 → identical packet on control_tx_packet one cycle later. A pending own REQ waits until an IDLE slot arrives.
- No reply for 64 cycles in WAIT → tx_error pulse. With RETRY_EN: 3 retries are re-injected, then tx_error on the 4th failure.
- RX FIFO full with simultaneous push+pop → rx_count stays 16. Data from src≠data_rx_node_id is dropped.
- rst asserted during SEND → next cycle all outputs 0, FIFOs empty, no tx_done.
